// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types for the pong match sequencer: FSM state
//               encoding and winner codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Match phases; any other encoding is treated as corrupt and recovers to IDLE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pong_match_seq_if.sv
`default_nettype none
// ============================================================================
// Interface   : pong_match_seq_if
// Description : Signals between the match sequencer and the pong game /
//               player controls. master = sequencer, slave = game side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_match_seq_if #(
  parameter int SCORE_W = 4
);
  logic               endframe;
  logic               start_btn;
  logic               goal_p1;
  logic               goal_p2;
  logic               game_rst;
  logic               play;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [1:0]         winner;
  logic               serve_dir;
  logic               snd_evt;

  modport master (
    input  endframe, start_btn, goal_p1, goal_p2,
    output game_rst, play, score_p1, score_p2, winner, serve_dir, snd_evt
  );

  modport slave (
    output endframe, start_btn, goal_p1, goal_p2,
    input  game_rst, play, score_p1, score_p2, winner, serve_dir, snd_evt
  );
endinterface
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ============================================================================
// Module      : edge_det
// Description : Registered rising-edge detector. The pulse appears for one
//               clock, one cycle after the input is first sampled high.
//               INIT sets the history bit after reset: 1 means an input that
//               is already high when reset releases does not count as an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Remember the previous sample and flag a low-to-high transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= INIT;
      pulse <= 1'b0;
    end else begin
      d_q   <= d;
      pulse <= d & ~d_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_match_seq.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_seq
// Description : Match sequencer for the pong game. Steps through
//               idle -> serve countdown -> rally -> point pause -> serve ...
//               until a player reaches WIN_SCORE, timing in video frames.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_match_seq
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4,
  parameter int FRM_W        = 8
) (
  input  logic              px_clk,
  input  logic              reset_n,
  pong_match_seq_if.master  bus
);

  localparam logic [FRM_W-1:0]   SERVE_CNT = FRM_W'(SERVE_FRAMES);
  localparam logic [FRM_W-1:0]   POINT_CNT = FRM_W'(POINT_FRAMES);
  localparam logic [FRM_W-1:0]   CNT_ONE   = FRM_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  state_t             state;
  logic [FRM_W-1:0]   cnt;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [1:0]         winner;
  logic               game_rst;
  logic               play;
  logic               serve_dir;
  logic               snd_evt;
  logic               frame_tick;
  logic               start_edge;

  // One tick per video frame
  edge_det #(.INIT(1'b0)) u_frame_edge (
    .clk   (px_clk),
    .rst_n (reset_n),
    .d     (bus.endframe),
    .pulse (frame_tick)
  );

  // Button history starts "pressed" so a button held through reset is not a start
  edge_det #(.INIT(1'b1)) u_start_edge (
    .clk   (px_clk),
    .rst_n (reset_n),
    .d     (bus.start_btn),
    .pulse (start_edge)
  );

  // Match FSM with shared frame down-counter, scores and registered outputs
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      score_p1  <= '0;
      score_p2  <= '0;
      winner    <= WIN_NONE;
      game_rst  <= 1'b1;
      play      <= 1'b0;
      serve_dir <= 1'b0;
      snd_evt   <= 1'b0;
    end else begin
      snd_evt <= 1'b0;
      case (state)
        IDLE, OVER: begin
          game_rst <= 1'b1;
          play     <= 1'b0;
          if (start_edge) begin
            score_p1 <= '0;
            score_p2 <= '0;
            winner   <= WIN_NONE;
            cnt      <= SERVE_CNT;
            state    <= SERVE;
          end
        end
        SERVE: begin
          game_rst <= 1'b1;
          play     <= 1'b0;
          if (frame_tick) begin
            cnt <= cnt - CNT_ONE;
            if (cnt <= CNT_ONE) begin
              game_rst <= 1'b0;
              play     <= 1'b1;
              state    <= RALLY;
            end
          end
        end
        RALLY: begin
          game_rst <= 1'b0;
          play     <= 1'b1;
          // A goal takes priority over a coincident frame tick
          if (bus.goal_p1 || bus.goal_p2) begin
            play    <= 1'b0;
            snd_evt <= 1'b1;
            cnt     <= POINT_CNT;
            state   <= POINT;
            // Simultaneous goals are a void point: no score, serve unchanged
            if (bus.goal_p1 && !bus.goal_p2) begin
              if (score_p1 != WIN_VAL) score_p1 <= score_p1 + SCORE_ONE;
              serve_dir <= 1'b1;
            end else if (bus.goal_p2 && !bus.goal_p1) begin
              if (score_p2 != WIN_VAL) score_p2 <= score_p2 + SCORE_ONE;
              serve_dir <= 1'b0;
            end
          end
        end
        POINT: begin
          game_rst <= 1'b0;
          play     <= 1'b0;
          if (frame_tick) begin
            cnt <= cnt - CNT_ONE;
            if (cnt <= CNT_ONE) begin
              game_rst <= 1'b1;
              if (score_p1 == WIN_VAL) begin
                winner  <= WIN_P1;
                snd_evt <= 1'b1;
                state   <= OVER;
              end else if (score_p2 == WIN_VAL) begin
                winner  <= WIN_P2;
                snd_evt <= 1'b1;
                state   <= OVER;
              end else begin
                cnt   <= SERVE_CNT;
                state <= SERVE;
              end
            end
          end
        end
        default: begin
          game_rst <= 1'b1;
          play     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.game_rst  = game_rst;
  assign bus.play      = play;
  assign bus.score_p1  = score_p1;
  assign bus.score_p2  = score_p2;
  assign bus.winner    = winner;
  assign bus.serve_dir = serve_dir;
  assign bus.snd_evt   = snd_evt;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_match_seq
// Description : Self-checking bench for pong_match_seq: random buttons and
//               goals against a phase-level reference model of the match.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_seq;

  localparam int SERVE_F = 3;
  localparam int POINT_F = 2;
  localparam int WIN_S   = 2;
  localparam int SW      = 4;

  logic px_clk  = 1'b0;
  logic reset_n = 1'b0;

  always #5 px_clk = ~px_clk;

  pong_match_seq_if #(.SCORE_W(SW)) bus ();

  pong_match_seq #(
    .SERVE_FRAMES (SERVE_F),
    .POINT_FRAMES (POINT_F),
    .WIN_SCORE    (WIN_S),
    .SCORE_W      (SW),
    .FRM_W        (8)
  ) dut (
    .px_clk  (px_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: the match as a phase plus frames left in that phase
  typedef enum {M_IDLE, M_SERVE, M_RALLY, M_POINT, M_OVER} mphase_t;
  mphase_t m_phase;
  int      m_left, m_s1, m_s2, m_win, m_dir, m_snd;
  logic    m_tick_pend, m_ef_last, m_start_pend, m_st_last;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase      = M_IDLE;
    m_left       = 0;
    m_s1         = 0;
    m_s2         = 0;
    m_win        = 0;
    m_dir        = 0;
    m_snd        = 0;
    m_tick_pend  = 1'b0;
    m_ef_last    = 1'b0;
    m_start_pend = 1'b0;
    m_st_last    = 1'b1;  // a button already down at reset release is not a press
  endtask

  // Advance the match by one clock given the inputs presented at that edge
  task automatic model_step();
    logic tick, st;
    tick         = m_tick_pend;
    st           = m_start_pend;
    m_tick_pend  = bus.endframe & ~m_ef_last;
    m_ef_last    = bus.endframe;
    m_start_pend = bus.start_btn & ~m_st_last;
    m_st_last    = bus.start_btn;
    m_snd        = 0;
    case (m_phase)
      M_IDLE, M_OVER: if (st) begin
        m_s1 = 0; m_s2 = 0; m_win = 0;
        m_left = SERVE_F; m_phase = M_SERVE;
      end
      M_SERVE: if (tick) begin
        m_left--;
        if (m_left == 0) m_phase = M_RALLY;
      end
      M_RALLY: if (bus.goal_p1 || bus.goal_p2) begin
        if (bus.goal_p1 && !bus.goal_p2) begin
          m_s1 = (m_s1 + 1 > WIN_S) ? WIN_S : m_s1 + 1; m_dir = 1;
        end else if (bus.goal_p2 && !bus.goal_p1) begin
          m_s2 = (m_s2 + 1 > WIN_S) ? WIN_S : m_s2 + 1; m_dir = 0;
        end
        m_snd = 1; m_left = POINT_F; m_phase = M_POINT;
      end
      M_POINT: if (tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 == WIN_S)      begin m_win = 1; m_snd = 1; m_phase = M_OVER; end
          else if (m_s2 == WIN_S) begin m_win = 2; m_snd = 1; m_phase = M_OVER; end
          else begin m_left = SERVE_F; m_phase = M_SERVE; end
        end
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    int exp_rst, exp_play;
    exp_rst  = (m_phase == M_IDLE || m_phase == M_SERVE || m_phase == M_OVER) ? 1 : 0;
    exp_play = (m_phase == M_RALLY) ? 1 : 0;
    check("game_rst",  32'(bus.game_rst),  32'(exp_rst));
    check("play",      32'(bus.play),      32'(exp_play));
    check("score_p1",  32'(bus.score_p1),  32'(m_s1));
    check("score_p2",  32'(bus.score_p2),  32'(m_s2));
    check("winner",    32'(bus.winner),    32'(m_win));
    check("serve_dir", 32'(bus.serve_dir), 32'(m_dir));
    check("snd_evt",   32'(bus.snd_evt),   32'(m_snd));
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge
  task automatic cycle();
    @(posedge px_clk);
    if (reset_n) model_step();
    @(negedge px_clk);
    compare_all();
    cyc++;
    bus.endframe = (cyc % 10 == 0);
  endtask

  // Pull reset between edges and check outputs before the next rising edge
  task automatic async_reset_check();
    @(negedge px_clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge px_clk);
    compare_all();
    bus.goal_p1   = 1'b0;
    bus.goal_p2   = 1'b0;
    bus.start_btn = 1'b0;
    reset_n       = 1'b1;
  endtask

  task automatic drive_random();
    int r;
    bus.goal_p1 = 1'b0;
    bus.goal_p2 = 1'b0;
    if ($urandom_range(0, 14) == 0) begin
      r = $urandom_range(0, 4);
      if (r == 0)     begin bus.goal_p1 = 1'b1; bus.goal_p2 = 1'b1; end
      else if (r < 3) bus.goal_p1 = 1'b1;
      else            bus.goal_p2 = 1'b1;
    end
    if ($urandom_range(0, 11) == 0) bus.start_btn = ~bus.start_btn;
  endtask

  initial begin
    int  budget;
    bit  reached;

    // Button held through reset: no start may follow
    bus.endframe  = 1'b0;
    bus.start_btn = 1'b1;
    bus.goal_p1   = 1'b0;
    bus.goal_p2   = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge px_clk);
      compare_all();
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.goal_p1 = (i % 7 == 3);
      bus.goal_p2 = (i % 9 == 5);
      cycle();
    end
    bus.goal_p1 = 1'b0;
    bus.goal_p2 = 1'b0;

    // Random play, with one reset dropped in at an arbitrary point
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
      if (i == 1500) async_reset_check();
    end

    // Steer into a rally where player 1 already has one point
    budget  = 0;
    reached = 0;
    while (!reached && budget < 3000) begin
      bus.goal_p1 = 1'b0;
      bus.goal_p2 = 1'b0;
      if (m_phase == M_RALLY && m_s1 == 1) begin
        reached = 1;
      end else begin
        if (m_phase == M_IDLE || m_phase == M_OVER) bus.start_btn = ~bus.start_btn;
        else bus.start_btn = 1'b0;
        if (m_phase == M_RALLY && m_s1 == 0) bus.goal_p1 = 1'b1;
        cycle();
        budget++;
      end
    end
    check("reach_rally_p1_1", 32'(reached), 32'd1);
    if (reached) begin
      check("pre_reset_score_p1", 32'(bus.score_p1), 32'd1);
      async_reset_check();
    end

    for (int i = 0; i < 200; i++) begin
      drive_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
